// File: rtl/pwm_pkg.sv
// pwm_pkg: shared widths, sync byte, frame lengths and FSM encoding for the PWM command path (frame format set by PWM_CMD_CHECKSUM_EN)
package pwm_pkg;
  localparam int PWM_W = 16;
  localparam logic [7:0] PWM_SYNC_BYTE = 8'hA5;
  localparam int PWM_FRAME_LEN_CSUM = 7;
  localparam int PWM_FRAME_LEN_NOCSUM = 6;
  typedef enum logic [2:0] {ST_IDLE, ST_CH, ST_PW_H, ST_PW_L, ST_CW_H, ST_CW_L, ST_CSUM} pwm_state_e;
endpackage

// File: rtl/pwm_cmd_decoder_if.sv
// pwm_cmd_decoder_if: received-byte stream from the UART into the command decoder
interface pwm_cmd_decoder_if;
  logic [7:0] rx_data;
  logic rx_valid;
  modport master (output rx_data, rx_valid);
  modport slave (input rx_data, rx_valid);
endinterface

// File: rtl/pwm_byte_timer.sv
// pwm_byte_timer: inter-byte idle counter with a single-cycle expiry strobe
module pwm_byte_timer #(
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic clk,
  input  logic reset,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expired
);
  localparam int W = $clog2(TIMEOUT_CYCLES);
  localparam logic [W-1:0] LAST = W'(TIMEOUT_CYCLES - 1);
  logic [W-1:0] r_cnt;
  assign o_expired = i_enable && !i_clear && r_cnt == LAST;
  // count idle cycles while a frame is open; a byte or expiry restarts the count
  always_ff @(posedge clk)
    if (reset || i_clear || o_expired) r_cnt <= '0;
    else if (i_enable) r_cnt <= r_cnt + W'(1);
endmodule

// File: rtl/pwm_cmd_decoder.sv
// pwm_cmd_decoder: parses UART command frames into the per-channel PWM width bank; PWM_CMD_CHECKSUM_EN adds the trailing XOR checksum byte
module pwm_cmd_decoder import pwm_pkg::*; #(
  parameter int NUM_CH = 8,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic                    clk,
  input  logic                    reset,
  pwm_cmd_decoder_if.slave        i_rx,
  output logic [NUM_CH*PWM_W-1:0] o_pulse_widths,
  output logic [NUM_CH*PWM_W-1:0] o_cycle_widths,
  output logic                    o_frame_ok,
  output logic                    o_frame_err
);
  pwm_state_e r_state;
  logic [7:0] r_ch, r_cw_h;
  logic [PWM_W-1:0] r_pw;
  logic [NUM_CH-1:0][PWM_W-1:0] r_pw_bank, r_cw_bank;
  logic r_ok, r_err;
  logic w_expired, w_last, w_good, w_bad_ch;
  logic [PWM_W-1:0] w_cw;
`ifdef PWM_CMD_CHECKSUM_EN
  logic [7:0] r_cw_l, r_csum;
  assign w_last = r_state == ST_CSUM;
  assign w_cw   = {r_cw_h, r_cw_l};
  assign w_good = r_csum == i_rx.rx_data && r_pw <= w_cw;
  // running XOR over CH..CW_L (CH restarts it) and the low cycle-width byte
  always_ff @(posedge clk)
    if (reset) begin
      r_csum <= '0;
      r_cw_l <= '0;
    end else if (i_rx.rx_valid) begin
      r_csum <= r_state == ST_CH ? i_rx.rx_data : r_csum ^ i_rx.rx_data;
      r_cw_l <= r_state == ST_CW_L ? i_rx.rx_data : r_cw_l;
    end
`else
  assign w_last = r_state == ST_CW_L;
  assign w_cw   = {r_cw_h, i_rx.rx_data};
  assign w_good = r_pw <= w_cw;
`endif
  assign w_bad_ch       = int'(i_rx.rx_data) >= NUM_CH;
  assign o_pulse_widths = r_pw_bank;
  assign o_cycle_widths = r_cw_bank;
  assign o_frame_ok     = r_ok;
  assign o_frame_err    = r_err;
  pwm_byte_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timer (
    .clk(clk),
    .reset(reset),
    .i_clear(i_rx.rx_valid || r_state == ST_IDLE),
    .i_enable(r_state != ST_IDLE),
    .o_expired(w_expired)
  );
  // frame FSM, staging registers and atomic per-channel commit; a byte always beats a timeout
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_ch      <= '0;
      r_pw      <= '0;
      r_cw_h    <= '0;
      r_pw_bank <= '0;
      r_cw_bank <= '0;
      r_ok      <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_ok  <= 1'b0;
      r_err <= 1'b0;
      if (i_rx.rx_valid && w_last) begin
        r_ok    <= w_good;
        r_err   <= !w_good;
        r_state <= ST_IDLE;
        for (int n = 0; n < NUM_CH; n++)
          if (w_good && r_ch == 8'(n)) begin
            r_pw_bank[n] <= r_pw;
            r_cw_bank[n] <= w_cw;
          end
      end else if (i_rx.rx_valid) begin
        case (r_state)
          ST_IDLE: r_state <= i_rx.rx_data == PWM_SYNC_BYTE ? ST_CH : ST_IDLE;
          ST_CH: begin
            r_ch    <= i_rx.rx_data;
            r_err   <= w_bad_ch;
            r_state <= w_bad_ch ? ST_IDLE : ST_PW_H;
          end
          ST_PW_H: begin
            r_pw[15:8] <= i_rx.rx_data;
            r_state    <= ST_PW_L;
          end
          ST_PW_L: begin
            r_pw[7:0] <= i_rx.rx_data;
            r_state   <= ST_CW_H;
          end
          ST_CW_H: begin
            r_cw_h  <= i_rx.rx_data;
            r_state <= ST_CW_L;
          end
          ST_CW_L: r_state <= ST_CSUM;
          default: r_state <= ST_IDLE;
        endcase
      end else if (w_expired) begin
        r_err   <= 1'b1;
        r_state <= ST_IDLE;
      end
    end
  end
endmodule

// File: tb/tb_pwm_cmd_decoder.sv
// tb_pwm_cmd_decoder: directed self-checking bench for pwm_cmd_decoder
module tb_pwm_cmd_decoder;
  import pwm_pkg::*;
  localparam int NC = 8;
  localparam int TO = 16;
  localparam int BW = NC * PWM_W;
`ifdef PWM_CMD_CHECKSUM_EN
  localparam int FLEN = PWM_FRAME_LEN_CSUM;
`else
  localparam int FLEN = PWM_FRAME_LEN_NOCSUM;
`endif
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [BW-1:0] pw_o, cw_o, want_pw, want_cw;
  logic ok_o, err_o;
  int n_chk = 0;
  int n_err = 0;
  pwm_cmd_decoder_if u_if();
  pwm_cmd_decoder #(.NUM_CH(NC), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk),
    .reset(reset),
    .i_rx(u_if),
    .o_pulse_widths(pw_o),
    .o_cycle_widths(cw_o),
    .o_frame_ok(ok_o),
    .o_frame_err(err_o)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [BW-1:0] got, input logic [BW-1:0] want);
    n_chk++;
    assert (got === want) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, want);
    end
  endtask
  task automatic chk_flags(input string tag, input logic ok, input logic err);
    chk({tag, "_ok"}, BW'(ok_o), BW'(ok));
    chk({tag, "_err"}, BW'(err_o), BW'(err));
  endtask
  task automatic chk_bank(input string tag);
    chk({tag, "_pw"}, pw_o, want_pw);
    chk({tag, "_cw"}, cw_o, want_cw);
  endtask
  task automatic set_want(input int ch, input logic [15:0] pw, input logic [15:0] cw);
    want_pw[ch*PWM_W +: PWM_W] = pw;
    want_cw[ch*PWM_W +: PWM_W] = cw;
  endtask
  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    u_if.rx_valid = 1'b1;
    u_if.rx_data  = b;
    @(posedge clk);
    #1;
    u_if.rx_valid = 1'b0;
  endtask
  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic send_frame(input logic [7:0] ch, input logic [15:0] pw, input logic [15:0] cw, input logic [7:0] flip);
    logic [7:0] b [7];
    b = '{8'hA5, ch, pw[15:8], pw[7:0], cw[15:8], cw[7:0], ch ^ pw[15:8] ^ pw[7:0] ^ cw[15:8] ^ cw[7:0] ^ flip};
    for (int i = 0; i < FLEN - 1; i++) send_byte(b[i]);
    chk("pre_commit_pw", pw_o, want_pw);
    chk("pre_commit_ok", BW'(ok_o), '0);
    send_byte(b[FLEN-1]);
  endtask
  initial begin
    u_if.rx_valid = 1'b0;
    u_if.rx_data  = 8'h00;
    want_pw = '0;
    want_cw = '0;
    idle(3);
    chk_bank("reset");
    chk_flags("reset", 1'b0, 1'b0);
    reset = 1'b0;
    send_frame(8'd2, 16'h0100, 16'h03E8, 8'h00);
    set_want(2, 16'h0100, 16'h03E8);
    chk_flags("ch2", 1'b1, 1'b0);
    chk_bank("ch2");
    idle(1);
    chk_flags("ch2_once", 1'b0, 1'b0);
`ifdef PWM_CMD_CHECKSUM_EN
    send_frame(8'd2, 16'h0100, 16'h03E8, 8'hE8);
    chk_flags("bad_csum", 1'b0, 1'b1);
    chk_bank("bad_csum");
    idle(1);
    chk_flags("bad_csum_once", 1'b0, 1'b0);
`endif
    send_byte(8'hA5);
    send_byte(8'h09);
    chk_flags("bad_ch", 1'b0, 1'b1);
    send_frame(8'd7, 16'h1234, 16'h5678, 8'h00);
    set_want(7, 16'h1234, 16'h5678);
    chk_flags("after_bad_ch", 1'b1, 1'b0);
    chk_bank("after_bad_ch");
    send_frame(8'd1, 16'h0005, 16'h0004, 8'h00);
    chk_flags("pw_gt_cw", 1'b0, 1'b1);
    chk_bank("pw_gt_cw");
    send_frame(8'd0, 16'h00FF, 16'h00FF, 8'h00);
    set_want(0, 16'h00FF, 16'h00FF);
    chk_flags("pw_eq_cw", 1'b1, 1'b0);
    chk_bank("pw_eq_cw");
    send_byte(8'hA5);
    send_byte(8'h03);
    idle(TO - 1);
    chk_flags("to_early", 1'b0, 1'b0);
    idle(1);
    chk_flags("to_fire", 1'b0, 1'b1);
    idle(1);
    chk_flags("to_once", 1'b0, 1'b0);
    send_byte(8'hA5);
    send_byte(8'h03);
    idle(TO - 1);
    send_byte(8'h00);
    chk_flags("to_byte_wins", 1'b0, 1'b0);
    send_byte(8'h10);
    send_byte(8'h00);
    idle(TO - 1);
    send_byte(8'h20);
`ifdef PWM_CMD_CHECKSUM_EN
    chk_flags("to_mid", 1'b0, 1'b0);
    send_byte(8'h33);
`endif
    set_want(3, 16'h0010, 16'h0020);
    chk_flags("to_commit", 1'b1, 1'b0);
    chk_bank("to_commit");
    send_byte(8'hA5);
    send_byte(8'h04);
    send_byte(8'h12);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    want_pw = '0;
    want_cw = '0;
    chk_bank("mid_reset");
    chk_flags("mid_reset", 1'b0, 1'b0);
    send_byte(8'h00);
    send_byte(8'hFF);
    chk_flags("junk", 1'b0, 1'b0);
    send_frame(8'd5, 16'h0000, 16'h0000, 8'h00);
    chk_flags("zero_widths", 1'b1, 1'b0);
    send_frame(8'd6, 16'hA5A5, 16'hFFFF, 8'h00);
    set_want(6, 16'hA5A5, 16'hFFFF);
    chk_flags("a5_as_data", 1'b1, 1'b0);
    chk_bank("a5_as_data");
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/pwm_cmd_decoder.md
# pwm_cmd_decoder

Byte-stream command decoder that sits directly upstream of the PWM channel array. It parses fixed-length frames from the UART receiver, validates them, and maintains the per-channel `pulse_width`/`cycle_width` register bank that drives every PWM channel. A committed frame updates exactly one channel's pair atomically. The channel applies the new values at its next cycle boundary.

## Interface
- `NUM_CH`, default 8: number of PWM channels; legal range 1..256.
- `TIMEOUT_CYCLES`, default 100000: maximum idle clk cycles between bytes inside a frame; must be ≥ 2.
- `clk`  in  1: clock.
- `reset`  in  1: reset, synchronous, active-high.
- `rx_data`  in  8: received byte; qualified by `rx_valid`.
- `rx_valid`  in  1: single-cycle strobe; every asserted cycle delivers one byte; no backpressure.
- `pulse_widths`  out  16*NUM_CH: channel n's pulse width at bits [16n+15:16n].
- `cycle_widths`  out  16*NUM_CH: channel n's cycle width, same packing.
- `frame_ok`  out  1: one-cycle pulse when a frame commits.
- `frame_err`  out  1: one-cycle pulse when a frame is discarded.

## Operation
- Frame format, in byte order: SYNC=0xA5, CH, PW_H, PW_L, CW_H, CW_L, CSUM.
  - CSUM = XOR of CH through CW_L.
  - Width values are big-endian.
- FSM states: IDLE, CH, PW_H, PW_L, CW_H, CW_L, CSUM. A state advances only on `rx_valid`.
- IDLE:
  - Byte 0xA5 → CH.
  - Any other byte → stay in IDLE; no error flagged. This is resynchronisation.
- CH:
  - CH ≥ NUM_CH → `frame_err`, return to IDLE.
  - Otherwise latch the channel index and go to PW_H.
- PW_H, PW_L, CW_H, CW_L: latch the byte into the staging registers; the running XOR accumulates.
- End of frame (CSUM byte):
  - Commit only if the checksum matches and pw ≤ cw.
  - On commit, write both 16-bit fields of the addressed channel, pulse `frame_ok`, and return to IDLE.
  - Otherwise pulse `frame_err` and return to IDLE; no register changes.
- pw = 0 and cw = 0 are legal.
- Timeout:
  - A byte counter clears on every `rx_valid` and on entry to IDLE.
  - In any non-IDLE state, when the counter reaches TIMEOUT_CYCLES−1 without a byte: `frame_err`, return to IDLE.
- Simultaneous byte and timeout in the same cycle: the byte wins and the timeout is suppressed.
- A 0xA5 byte inside a frame is data, not a resync.
- Reset, including mid-frame:
  - FSM → IDLE; staging registers and counter cleared.
  - All `pulse_widths`/`cycle_widths` = 0, so channels go quiet.
  - `frame_ok` = `frame_err` = 0.

## Timing
- Commit latency: register bank update, `frame_ok`, and `frame_err` are all registered. They become visible in the cycle after the clk edge that samples the final byte's `rx_valid`.
- Outputs never change except on commit or reset. Unaddressed channels are never touched.
- `frame_ok` and `frame_err` are mutually exclusive.
- Back-to-back frames with `rx_valid` asserted every cycle are fully supported; there are no dead cycles between frames.
- Timeout fires after exactly TIMEOUT_CYCLES cycles without a byte following the last accepted byte.

## Configuration
- `PWM_CMD_CHECKSUM_EN` defined:
  - 7-byte frame as above.
  - A CSUM mismatch discards the frame with `frame_err`.
- Not defined:
  - 6-byte frame with no CSUM state.
  - The commit decision (pw ≤ cw) is taken on the CW_L byte, with the same one-cycle latency.
  - No XOR logic is instantiated.

## Structure
- Shared package `pwm_pkg`:
  - `PWM_W = 16`
  - `PWM_SYNC_BYTE = 8'hA5`
  - FSM state enum
  - Frame length constants for both configurations
- One sub-module: `pwm_byte_timer`, the inter-byte timeout counter.
  - Inputs: clear, enable.
  - Output: single-cycle `expired`.
  - Counter width: $clog2(TIMEOUT_CYCLES).
- The register bank and FSM live in the top level.

## Test plan
- Reset → all width outputs 0, both flags 0.
- Frame A5 02 01 00 03 E8 E8 (checksum enabled) → ch2 pw=0x0100, cw=0x03E8. `frame_ok` pulses once. Channels 0, 1, 3..7 remain 0.
- Same frame with CSUM=0x00 → `frame_err` once; ch2 unchanged.
- Frame A5 09 … with NUM_CH=8 → `frame_err` after the CH byte; the following valid frame commits normally.
- Frame A5 01 00 05 00 04 (checksum 00) → pw > cw → `frame_err`, no update.
- TIMEOUT_CYCLES=16: send A5 03 then wait 16 cycles → `frame_err` on cycle 16. With a byte on cycle 16 instead → no error.
- Mid-frame reset, or junk bytes 00 FF before A5 → the FSM resynchronises and the next frame commits.
